// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute-stage front end.
// The optional condition-field register is present only when COND_EXEC_EN is defined.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_ctrl;
    logic [1:0] flag_w;
`ifdef COND_EXEC_EN
    cond_e      cond;
`endif
  } idex_ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against NZCV flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ok
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    cond_ok = 1'b1;
    case (cond_e'(cond))
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = !z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = !c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = !n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = !v;
      COND_HI: cond_ok = c && !z;
      COND_LS: cond_ok = !c || z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = !z && (n == v);
      COND_LE: cond_ok = z || (n != v);
      default: cond_ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// ID/EX control register, NZCV flags register and condition-qualified control outputs.
// Define COND_EXEC_EN to enable condition evaluation; otherwise every valid instruction executes.
module cond_exec_stage
  import cpu_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  logic       d_valid,
  input  logic       d_reg_w,
  input  logic       d_mem_w,
  input  logic       d_mem_to_reg,
  input  logic       d_alu_src,
  input  logic       d_branch,
  input  logic [1:0] d_alu_ctrl,
  input  logic [1:0] d_flag_w,
  input  logic [3:0] d_cond,
  input  logic [3:0] alu_flags,
  output logic       e_valid,
  output logic       e_reg_w,
  output logic       e_mem_w,
  output logic       e_mem_to_reg,
  output logic       e_alu_src,
  output logic [1:0] e_alu_ctrl,
  output logic       e_pc_src,
  output logic       cond_ok,
  output logic [3:0] flags
);

  idex_ctrl_t ctrl_q, ctrl_d;
  logic [3:0] flags_q, flags_d;
  logic       flags_upd;

  always_comb begin
    ctrl_d = ctrl_q;
    if (flush) begin
      ctrl_d = '0;
    end else if (!stall) begin
      ctrl_d.valid      = d_valid;
      ctrl_d.reg_w      = d_reg_w;
      ctrl_d.mem_w      = d_mem_w;
      ctrl_d.mem_to_reg = d_mem_to_reg;
      ctrl_d.alu_src    = d_alu_src;
      ctrl_d.branch     = d_branch;
      ctrl_d.alu_ctrl   = d_alu_ctrl;
      ctrl_d.flag_w     = d_flag_w;
`ifdef COND_EXEC_EN
      ctrl_d.cond       = cond_e'(d_cond);
`endif
    end
  end

`ifdef COND_EXEC_EN
  cond_check u_cond_check (
    .cond    (ctrl_q.cond),
    .flags   (flags_q),
    .cond_ok (cond_ok)
  );
`else
  logic unused_cond;
  assign unused_cond = ^d_cond;
  assign cond_ok     = 1'b1;
`endif

  // The E-stage instruction leaves on a flush even when stalled, so it commits its flags then.
  always_comb begin
    flags_d   = flags_q;
    flags_upd = ctrl_q.valid && cond_ok && (!stall || flush);
    if (flags_upd) begin
      if (ctrl_q.flag_w[1]) begin
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (ctrl_q.flag_w[0]) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      flags_q <= RESET_FLAGS;
    end else begin
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
    end
  end

  assign e_valid      = ctrl_q.valid;
  assign e_reg_w      = ctrl_q.valid && ctrl_q.reg_w && cond_ok;
  assign e_mem_w      = ctrl_q.valid && ctrl_q.mem_w && cond_ok;
  assign e_pc_src     = ctrl_q.valid && ctrl_q.branch && cond_ok;
  assign e_mem_to_reg = ctrl_q.mem_to_reg;
  assign e_alu_src    = ctrl_q.alu_src;
  assign e_alu_ctrl   = ctrl_q.alu_ctrl;
  assign flags        = flags_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Randomized and directed bench for cond_exec_stage against a behavioural model.
module tb_cond_exec_stage;

  logic       clk = 1'b0;
  logic       rst, stall, flush;
  logic       d_valid, d_reg_w, d_mem_w, d_mem_to_reg, d_alu_src, d_branch;
  logic [1:0] d_alu_ctrl, d_flag_w;
  logic [3:0] d_cond, alu_flags;
  logic       e_valid, e_reg_w, e_mem_w, e_mem_to_reg, e_alu_src, e_pc_src, cond_ok;
  logic [1:0] e_alu_ctrl;
  logic [3:0] flags;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  cond_exec_stage #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .d_valid(d_valid), .d_reg_w(d_reg_w), .d_mem_w(d_mem_w),
    .d_mem_to_reg(d_mem_to_reg), .d_alu_src(d_alu_src), .d_branch(d_branch),
    .d_alu_ctrl(d_alu_ctrl), .d_flag_w(d_flag_w), .d_cond(d_cond),
    .alu_flags(alu_flags),
    .e_valid(e_valid), .e_reg_w(e_reg_w), .e_mem_w(e_mem_w),
    .e_mem_to_reg(e_mem_to_reg), .e_alu_src(e_alu_src), .e_alu_ctrl(e_alu_ctrl),
    .e_pc_src(e_pc_src), .cond_ok(cond_ok), .flags(flags)
  );

  // Reference model: the instruction sitting in E plus the architectural flags.
  bit       mv, mrw, mmw, mm2r, mas, mbr;
  bit [1:0] mac, mfw;
  bit [3:0] mcond, mflags;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pass(input int c, input bit [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
`ifndef COND_EXEC_EN
    return 1'b1;
`else
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
`endif
  endfunction

  task automatic model_reset();
    {mv, mrw, mmw, mm2r, mas, mbr} = '0;
    mac = '0; mfw = '0; mcond = '0; mflags = 4'b0000;
  endtask

  task automatic model_step();
    bit ok;
    ok = pass(int'(mcond), mflags);
    if (mv && ok && (!stall || flush)) begin
      if (mfw[1]) mflags[3:2] = alu_flags[3:2];
      if (mfw[0]) mflags[1:0] = alu_flags[1:0];
    end
    if (flush) begin
      {mv, mrw, mmw, mm2r, mas, mbr} = '0;
      mac = '0; mfw = '0; mcond = '0;
    end else if (!stall) begin
      mv = d_valid; mrw = d_reg_w; mmw = d_mem_w; mm2r = d_mem_to_reg;
      mas = d_alu_src; mbr = d_branch; mac = d_alu_ctrl; mfw = d_flag_w; mcond = d_cond;
    end
  endtask

  task automatic check_outputs();
    bit ok;
    ok = pass(int'(mcond), mflags);
    check("e_valid", 8'(e_valid), 8'(mv));
    check("e_reg_w", 8'(e_reg_w), 8'(mv && mrw && ok));
    check("e_mem_w", 8'(e_mem_w), 8'(mv && mmw && ok));
    check("e_pc_src", 8'(e_pc_src), 8'(mv && mbr && ok));
    check("e_mem_to_reg", 8'(e_mem_to_reg), 8'(mm2r));
    check("e_alu_src", 8'(e_alu_src), 8'(mas));
    check("e_alu_ctrl", 8'(e_alu_ctrl), 8'(mac));
    check("flags", 8'(flags), 8'(mflags));
    if (mv) check("cond_ok", 8'(cond_ok), 8'(ok));
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input bit mw, input bit br,
                       input bit [1:0] fw, input bit [3:0] cnd, input bit [3:0] af,
                       input bit st, input bit fl);
    d_valid = v; d_reg_w = rw; d_mem_w = mw; d_branch = br;
    d_mem_to_reg = 1'b0; d_alu_src = 1'b0; d_alu_ctrl = 2'b00;
    d_flag_w = fw; d_cond = cnd; alu_flags = af; stall = st; flush = fl;
  endtask

  task automatic drive_random();
    d_valid      = ($urandom_range(0, 9) < 8);
    d_reg_w      = 1'($urandom);
    d_mem_w      = 1'($urandom);
    d_mem_to_reg = 1'($urandom);
    d_alu_src    = 1'($urandom);
    d_branch     = 1'($urandom);
    d_alu_ctrl   = 2'($urandom);
    d_flag_w     = 2'($urandom);
    d_cond       = 4'($urandom);
    alu_flags    = 4'($urandom);
    stall        = ($urandom_range(0, 9) < 2);
    flush        = ($urandom_range(0, 9) < 1);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_flags", 8'(flags), 8'h00);
    check("reset_valid", 8'(e_valid), 8'h00);

    // Async reset while a valid write is in E
    drive(1, 1, 1, 0, 2'b11, 4'hE, 4'hF, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 0, 0);
    #2;
    check("pre_rst_reg_w", 8'(e_reg_w), 8'h01);
    rst = 1'b1;
    #1;
    check("async_rst_reg_w", 8'(e_reg_w), 8'h00);
    check("async_rst_mem_w", 8'(e_mem_w), 8'h00);
    check("async_rst_valid", 8'(e_valid), 8'h00);
    check("async_rst_flags", 8'(flags), 8'h00);
    rst = 1'b0;
    model_reset();
    cycle();

    // EQ taken: SUB sets Z, then EQ with reg_w
    drive(1, 0, 0, 0, 2'b11, 4'hE, 4'h4, 0, 0); cycle();
    drive(1, 1, 0, 0, 2'b00, 4'h0, 4'h0, 0, 0); cycle();
    check("eq_taken_reg_w", 8'(e_reg_w), 8'h01);
    check("eq_taken_cond_ok", 8'(cond_ok), 8'h01);
    // EQ not taken: SUB clears Z
    drive(1, 0, 0, 0, 2'b11, 4'hE, 4'h0, 0, 0); cycle();
    drive(1, 1, 0, 0, 2'b00, 4'h0, 4'h0, 0, 0); cycle();
`ifdef COND_EXEC_EN
    check("eq_not_taken_reg_w", 8'(e_reg_w), 8'h00);
`else
    check("eq_uncond_reg_w", 8'(e_reg_w), 8'h01);
`endif

    // Branch AL taken, branch EQ with Z=0
    drive(1, 0, 0, 1, 2'b00, 4'hE, 4'h0, 0, 0); cycle();
    check("branch_al_pc_src", 8'(e_pc_src), 8'h01);
    drive(1, 0, 0, 1, 2'b00, 4'h0, 4'h0, 0, 0); cycle();
`ifdef COND_EXEC_EN
    check("branch_eq_pc_src", 8'(e_pc_src), 8'h00);
`else
    check("branch_eq_pc_src", 8'(e_pc_src), 8'h01);
`endif

    // Partial flag write: 1111 then flag_w=10 with 0000 -> 0011
    drive(1, 0, 0, 0, 2'b11, 4'hE, 4'hF, 0, 0); cycle();
    drive(1, 0, 0, 0, 2'b10, 4'hE, 4'hF, 0, 0); cycle();
    check("flags_all_set", 8'(flags), 8'h0F);
    drive(0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 0, 0); cycle();
    check("flags_partial", 8'(flags), 8'h03);

    // Stall: flag-setting instruction held three cycles
    drive(1, 0, 0, 0, 2'b11, 4'hE, 4'hA, 0, 0); cycle();
    drive(0, 0, 0, 0, 2'b00, 4'h0, 4'hA, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flags_held_in_stall", 8'(flags), 8'h03);
    end
    drive(0, 0, 0, 0, 2'b00, 4'h0, 4'hA, 0, 0); cycle();
    check("flags_after_stall", 8'(flags), 8'h0A);

    // Flush and stall together still commits the E-stage flags
    drive(1, 0, 0, 0, 2'b11, 4'hE, 4'h5, 0, 0); cycle();
    drive(1, 1, 0, 0, 2'b00, 4'hE, 4'h5, 1, 1); cycle();
    check("flush_stall_valid", 8'(e_valid), 8'h00);
    check("flush_stall_flags", 8'(flags), 8'h05);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_random();
      cycle();
    end

    drive(0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 0, 0);
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
